hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage LEGv8 pipeline (IF/ID/EX/MEM/WB).
- Keeps a registered shadow of destination-register info for instructions in EX, MEM and WB.
- Produces:
  - stall and flush controls for the pipeline registers;
  - EX-stage forwarding selects;
  - decode-stage write-through bypass selects for the register file read ports.
- The decode stage uses the bypass selects instead of an inline compare.

Parameters:
- RB, 5, register index width.
- ZR, 31, index of XZR; never a hazard source.
- CNT_W, 32, width of statistics counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ra1_D  in  RB  decode read address 1 (instr_D[9:5]).
- ra2_D  in  RB  decode read address 2 (reg2loc mux output).
- wa_D  in  RB  decode destination (instr_D[4:0]).
- regWrite_D  in  1  decode instruction writes a register.
- memRead_D  in  1  decode instruction is a load.
- branchTaken_M  in  1  branch resolved taken in MEM.
- stall_F  out  1  hold PC.
- stall_D  out  1  hold IF/ID.
- flush_D  out  1  clear IF/ID.
- flush_E  out  1  clear ID/EX.
- flush_M  out  1  clear EX/MEM.
- fwdA_E  out  2  EX operand A select: 00 regfile, 01 WB result, 10 MEM ALU result.
- fwdB_E  out  2  EX operand B select, same encoding.
- bypass1_D  out  1  decode rd1 takes writeData3 (WB value).
- bypass2_D  out  1  decode rd2 takes writeData3.
- stallCount  out  CNT_W  load-use stall cycles (optional feature).
- flushCount  out  CNT_W  taken-branch flushes (optional feature).

Behaviour:
- Shadow state:
  - Entries E, M, W each hold {v, rw, mr, wa}.
  - Entry E additionally holds {ra1, ra2}.
  - On reset, all v=0 and all fields 0; all outputs 0 in the cycle after reset.
- Advance each cycle:
  - W<=M, M<=E.
  - E<={1, regWrite_D, memRead_D, wa_D, ra1_D, ra2_D}.
- Match definition: match(x,r) = x.v & x.rw & (x.wa==r) & (r!=ZR).
- Load-use hazard (combinational from current E and decode inputs):
  - luh = E.v & E.mr & match(E,ra1_D) | match(E,ra2_D), with the E.mr/E.v terms applying to both compares.
  - When luh asserts: stall_F=stall_D=1, and a bubble is inserted, i.e. next E.v=0.
  - M and W advance normally.
  - Exactly one stall cycle per load-use pair.
- Taken branch (branchTaken_M=1):
  - flush_D=flush_E=flush_M=1 that cycle.
  - Next E.v=0 and next M.v=0; W<=M still advances, because the branch itself continues.
- Priority: flush beats stall. If branchTaken_M and luh occur together, then stall_F=stall_D=0, the flushes assert, and the stall is not counted.
- Forwarding (combinational from registered shadow):
  - fwdA_E = 10 if match(M,E.ra1); else 01 if match(W,E.ra1); else 00. The MEM source has priority over WB.
  - fwdB_E: same rule using E.ra2.
  - Forwarding from a load in M never occurs, because luh guarantees separation.
- Decode bypass:
  - bypass1_D = match(W,ra1_D).
  - bypass2_D = match(W,ra2_D).
  - Combinational, same cycle as the register file write.
- Zero register: any reference to ZR yields no stall, no forward and no bypass, even when regWrite is set with wa=ZR.
- Reset mid-operation: all shadow state is invalidated on the next edge; no pending forwards or stalls survive reset.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - stallCount increments on each cycle with luh and no flush.
  - flushCount increments on each cycle with branchTaken_M.
  - Both saturate at all-ones and clear on reset.
- Undefined: no counters are synthesised, and both ports are driven constant 0.
- Port list is identical in both builds.

Test Plan:
- Load-use:
  - Stimulus: LDUR X1 in E (mr=1, wa=1), decode ra1_D=1.
  - Required: stall_F=stall_D=1 for exactly 1 cycle; next cycle E.v=0.
  - Required: two cycles later, fwdA_E=01 (load now in WB).
- ALU back-to-back:
  - Stimulus: ADD X2 issues, next instruction reads X2 on ra2.
  - Required: fwdB_E=10 in the consumer's EX cycle; no stall.
- Double hazard:
  - Stimulus: X3 written in both M and W, consumer reads X3 on ra1.
  - Required: fwdA_E=10 (MEM priority).
- Zero register:
  - Stimulus: load to wa=31, decode ra1_D=31.
  - Required: stall_F=0, fwdA_E=00, bypass1_D=0.
- Branch flush with stall:
  - Stimulus: branchTaken_M=1 while luh is true.
  - Required: flush_D/E/M=1, stall_F=stall_D=0.
  - Required next cycle: E.v=M.v=0, so fwdA_E=fwdB_E=00.
  - With HAZARD_STATS_EN: flushCount=1, stallCount=0.
- Decode bypass and reset:
  - Stimulus: W holds rw=1, wa=5; ra1_D=5, ra2_D=5.
  - Required: bypass1_D=bypass2_D=1.
  - Stimulus: assert reset one cycle.
  - Required: all outputs 0 and counters 0 after the edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage LEGv8 pipeline: load-use stall, taken-branch flush,
// EX forwarding selects and decode write-through bypass. Optional statistics counters: HAZARD_STATS_EN.
module hazard_ctrl #(
    parameter int unsigned RB    = 5,
    parameter int unsigned ZR    = 31,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RB-1:0]    ra1_D,
    input  logic [RB-1:0]    ra2_D,
    input  logic [RB-1:0]    wa_D,
    input  logic             regWrite_D,
    input  logic             memRead_D,
    input  logic             branchTaken_M,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic [1:0]       fwdA_E,
    output logic [1:0]       fwdB_E,
    output logic             bypass1_D,
    output logic             bypass2_D,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam logic [RB-1:0] ZR_IDX = RB'(ZR);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    typedef struct packed {
        logic          v;
        logic          rw;
        logic          mr;
        logic [RB-1:0] wa;
    } shadow_t;

    shadow_t       r_e;
    shadow_t       r_m;
    shadow_t       r_w;
    logic [RB-1:0] r_e_ra1;
    logic [RB-1:0] r_e_ra2;

    logic w_luh;
    logic w_flush;
    logic w_stall;
    logic w_bubble_e;

    // A valid register writer whose destination equals r; XZR never matches.
    function automatic logic f_match(input logic v, input logic rw,
                                     input logic [RB-1:0] wa, input logic [RB-1:0] r);
        return v & rw & (wa == r) & (r != ZR_IDX);
    endfunction

    // MEM result is younger than WB, so it wins when both hold the register.
    function automatic logic [1:0] f_fwd_sel(input shadow_t m, input shadow_t w,
                                             input logic [RB-1:0] r);
        logic [1:0] sel;
        sel = SEL_RF;
        if (f_match(m.v, m.rw, m.wa, r)) begin
            sel = SEL_MEM;
        end else if (f_match(w.v, w.rw, w.wa, r)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        w_luh      = r_e.v & r_e.mr &
                     (f_match(r_e.v, r_e.rw, r_e.wa, ra1_D) |
                      f_match(r_e.v, r_e.rw, r_e.wa, ra2_D));
        w_flush    = branchTaken_M;
        w_stall    = w_luh & ~w_flush;
        w_bubble_e = w_luh | w_flush;
    end

    // Shadow pipeline: W always advances; a flush kills E and M, a stall bubbles E.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e     <= '0;
            r_m     <= '0;
            r_w     <= '0;
            r_e_ra1 <= '0;
            r_e_ra2 <= '0;
        end else begin
            r_w <= r_m;
            r_m <= w_flush ? shadow_t'('0) : r_e;
            if (w_bubble_e) begin
                r_e     <= '0;
                r_e_ra1 <= '0;
                r_e_ra2 <= '0;
            end else begin
                r_e     <= '{v: 1'b1, rw: regWrite_D, mr: memRead_D, wa: wa_D};
                r_e_ra1 <= ra1_D;
                r_e_ra2 <= ra2_D;
            end
        end
    end

    assign stall_F   = w_stall;
    assign stall_D   = w_stall;
    assign flush_D   = w_flush;
    assign flush_E   = w_flush;
    assign flush_M   = w_flush;
    assign fwdA_E    = f_fwd_sel(r_m, r_w, r_e_ra1);
    assign fwdB_E    = f_fwd_sel(r_m, r_w, r_e_ra2);
    assign bypass1_D = f_match(r_w.v, r_w.rw, r_w.wa, ra1_D);
    assign bypass2_D = f_match(r_w.v, r_w.rw, r_w.wa, ra2_D);

    // The load flag is only needed in E; W keeps it for a uniform entry layout.
    logic w_unused_w_mr;
    assign w_unused_w_mr = r_w.mr;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stallCount = r_stall_cnt;
    assign flushCount = r_flush_cnt;
`else
    assign stallCount = '0;
    assign flushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, ALU forwarding, double hazard, XZR, flush-vs-stall,
// decode bypass and mid-run reset, with hand-computed expectations.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  ra1_D;
    logic [4:0]  ra2_D;
    logic [4:0]  wa_D;
    logic        regWrite_D;
    logic        memRead_D;
    logic        branchTaken_M;
    logic        stall_F;
    logic        stall_D;
    logic        flush_D;
    logic        flush_E;
    logic        flush_M;
    logic [1:0]  fwdA_E;
    logic [1:0]  fwdB_E;
    logic        bypass1_D;
    logic        bypass2_D;
    logic [31:0] stallCount;
    logic [31:0] flushCount;

    int total;
    int bad;
    int exp_stall;
    int exp_flush;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    hazard_ctrl #(.RB(5), .ZR(31), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .ra1_D         (ra1_D),
        .ra2_D         (ra2_D),
        .wa_D          (wa_D),
        .regWrite_D    (regWrite_D),
        .memRead_D     (memRead_D),
        .branchTaken_M (branchTaken_M),
        .stall_F       (stall_F),
        .stall_D       (stall_D),
        .flush_D       (flush_D),
        .flush_E       (flush_E),
        .flush_M       (flush_M),
        .fwdA_E        (fwdA_E),
        .fwdB_E        (fwdB_E),
        .bypass1_D     (bypass1_D),
        .bypass2_D     (bypass2_D),
        .stallCount    (stallCount),
        .flushCount    (flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] w,
                         input logic rw, input logic mr, input logic bt);
        ra1_D         = a1;
        ra2_D         = a2;
        wa_D          = w;
        regWrite_D    = rw;
        memRead_D     = mr;
        branchTaken_M = bt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_stallCount"}, stallCount, STATS ? 32'(exp_stall) : 32'd0);
        chk({tag, "_flushCount"}, flushCount, STATS ? 32'(exp_flush) : 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_stall_F"},   32'(stall_F),   32'd0);
        chk({tag, "_stall_D"},   32'(stall_D),   32'd0);
        chk({tag, "_flush_D"},   32'(flush_D),   32'd0);
        chk({tag, "_flush_E"},   32'(flush_E),   32'd0);
        chk({tag, "_flush_M"},   32'(flush_M),   32'd0);
        chk({tag, "_fwdA"},      32'(fwdA_E),    32'd0);
        chk({tag, "_fwdB"},      32'(fwdB_E),    32'd0);
        chk({tag, "_bypass1"},   32'(bypass1_D), 32'd0);
        chk({tag, "_bypass2"},   32'(bypass2_D), 32'd0);
        chk_counts(tag);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_stall = 0;
        exp_flush = 0;

        reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_idle("reset");

        // c0: LDUR X1 decoded
        drive(5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("c0_stall_F", 32'(stall_F), 32'd0);
        tick();

        // c1: consumer of X1 on ra1 -> one stall
        drive(5'd1, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_stall_F", 32'(stall_F), 32'd1);
        chk("lu_stall_D", 32'(stall_D), 32'd1);
        chk("lu_flush_E", 32'(flush_E), 32'd0);
        chk("lu_fwdA",    32'(fwdA_E),  32'd0);
        exp_stall++;
        tick();

        // c2: consumer held in decode, load moved on, bubble in E
        #1;
        chk("lu_once_stall_F", 32'(stall_F), 32'd0);
        chk("lu_once_stall_D", 32'(stall_D), 32'd0);
        chk("lu_bubble_fwdA",  32'(fwdA_E),  32'd0);
        chk_counts("lu_after");
        tick();

        // c3: consumer in EX, load in WB
        drive(5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_fwdA_wb",   32'(fwdA_E),    32'd1);
        chk("lu_fwdB",      32'(fwdB_E),    32'd0);
        chk("lu_bypass1",   32'(bypass1_D), 32'd0);
        chk("lu_bypass2",   32'(bypass2_D), 32'd1);
        chk("c3_stall_F",   32'(stall_F),   32'd0);
        tick();

        // c4: ADD X2
        drive(5'd9, 5'd10, 5'd2, 1'b1, 1'b0, 1'b0);
        #1;
        chk("c4_fwdA", 32'(fwdA_E), 32'd0);
        chk("c4_fwdB", 32'(fwdB_E), 32'd0);
        tick();

        // c5: reads X2 on ra2, producer is ALU -> no stall
        drive(5'd11, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0);
        #1;
        chk("alu_no_stall", 32'(stall_F), 32'd0);
        tick();

        // c6: consumer in EX, ADD X2 in MEM; decode ADD X3 (first)
        drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        chk("alu_fwdB_mem", 32'(fwdB_E), 32'd2);
        chk("alu_fwdA",     32'(fwdA_E), 32'd0);
        tick();

        // c7: ADD X3 (second)
        drive(5'd13, 5'd14, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        chk("c7_fwdA", 32'(fwdA_E), 32'd0);
        tick();

        // c8: consumer of X3 on ra1
        drive(5'd3, 5'd15, 5'd16, 1'b1, 1'b0, 1'b0);
        #1;
        chk("c8_fwdA", 32'(fwdA_E), 32'd0);
        tick();

        // c9: X3 in both MEM and WB; decode LDUR X31 reading X3
        drive(5'd3, 5'd20, 5'd31, 1'b1, 1'b1, 1'b0);
        #1;
        chk("dbl_fwdA_mem", 32'(fwdA_E),    32'd2);
        chk("dbl_bypass1",  32'(bypass1_D), 32'd1);
        tick();

        // c10: load to XZR in E, decode reads XZR
        drive(5'd31, 5'd31, 5'd17, 1'b1, 1'b0, 1'b0);
        #1;
        chk("zr_stall_F", 32'(stall_F),   32'd0);
        chk("zr_bypass1", 32'(bypass1_D), 32'd0);
        tick();

        // c11: XZR reader in EX, XZR load in MEM
        drive(5'd31, 5'd0, 5'd18, 1'b1, 1'b0, 1'b0);
        #1;
        chk("zr_fwdA", 32'(fwdA_E), 32'd0);
        chk("zr_fwdB", 32'(fwdB_E), 32'd0);
        tick();

        // c12: XZR load in WB; decode LDUR X4
        drive(5'd31, 5'd31, 5'd4, 1'b1, 1'b1, 1'b0);
        #1;
        chk("zr_wb_bypass1", 32'(bypass1_D), 32'd0);
        chk("zr_wb_bypass2", 32'(bypass2_D), 32'd0);
        chk("zr_wb_fwdA",    32'(fwdA_E),    32'd0);
        tick();

        // c13: load-use on X4 coincides with taken branch
        drive(5'd4, 5'd4, 5'd19, 1'b1, 1'b0, 1'b1);
        #1;
        chk("br_flush_D", 32'(flush_D), 32'd1);
        chk("br_flush_E", 32'(flush_E), 32'd1);
        chk("br_flush_M", 32'(flush_M), 32'd1);
        chk("br_stall_F", 32'(stall_F), 32'd0);
        chk("br_stall_D", 32'(stall_D), 32'd0);
        exp_flush++;
        tick();

        // c14: E and M killed, W still advanced (X18)
        drive(5'd18, 5'd4, 5'd19, 1'b1, 1'b0, 1'b0);
        #1;
        chk("br_fwdA",    32'(fwdA_E),    32'd0);
        chk("br_fwdB",    32'(fwdB_E),    32'd0);
        chk("br_nostall", 32'(stall_F),   32'd0);
        chk("br_flush_clr", 32'(flush_D), 32'd0);
        chk("br_w_adv",   32'(bypass1_D), 32'd1);
        chk_counts("br");
        tick();

        // c15..c17: ADD X5, nop, LDUR X7
        drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();

        // c18: X5 in WB, decode reads X5 on both ports
        drive(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("byp_bypass1", 32'(bypass1_D), 32'd1);
        chk("byp_bypass2", 32'(bypass2_D), 32'd1);
        chk("byp_stall_F", 32'(stall_F),   32'd0);
        drive(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_pre_stall", 32'(stall_F), 32'd1);

        // reset with a pending stall and bypass in flight
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        drive(5'd7, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_idle("rst_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
